dds_cmd_ctrl: RTL and testbench

Command sequencer between the UART receiver/transmitter and the DDS configuration registers. It takes one command byte at a time from the UART RX, validates it against the current mode, commits the payload into the matching DDS configuration register, and returns a one-byte acknowledge through the UART TX handshake. It is the single writer of all DDS configuration outputs.

---
 rtl/dds_cmd_pkg.sv | 35 +++
 rtl/dds_cmd_ctrl_if.sv | 31 +++
 rtl/dds_cmd_check.sv | 32 +++
 rtl/dds_cmd_ctrl.sv | 118 +++++++++++
 tb/tb_dds_cmd_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/dds_cmd_pkg.sv
// Shared definitions for the DDS command sequencer: opcode and mode
// encodings, FSM state encoding, acknowledge bytes and a one-hot helper.
package dds_cmd_pkg;

  typedef enum logic [2:0] {
    OP_FREQ0 = 3'd0,
    OP_FREQ1 = 3'd1,
    OP_FREQ2 = 3'd2,
    OP_FREQ3 = 3'd3,
    OP_PHASE = 3'd4,
    OP_AMP   = 3'd5,
    OP_WAVE  = 3'd6,
    OP_MODE  = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    APPLY   = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_e;

  localparam logic [3:0] MODE_A     = 4'b0001;
  localparam logic [3:0] MODE_B     = 4'b0010;
  localparam logic [3:0] RESET_MODE = MODE_A;

  localparam logic [7:0] ACK_OK  = 8'h01;
  localparam logic [7:0] ACK_ERR = 8'hFF;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v == 4'd1) || (v == 4'd2) || (v == 4'd4) || (v == 4'd8);
  endfunction

endpackage

// File: rtl/dds_cmd_ctrl_if.sv
// Bundle of UART RX/TX handshake and DDS configuration signals around the
// command sequencer.
//   slave  : the sequencer (consumes RX byte / TX busy, drives everything else)
//   master : the surrounding UART/DDS side
interface dds_cmd_ctrl_if;
  logic [7:0]  rx_data_in;
  logic        rx_valid_in;
  logic        tx_busy_in;
  logic [7:0]  tx_data_out;
  logic        tx_start_out;
  logic [19:0] freq_word_out;
  logic [4:0]  phase_out;
  logic [3:0]  amp_out;
  logic [3:0]  wave_out;
  logic [3:0]  mode_out;
  logic        cfg_update_out;
  logic        ovf_out;
  logic        busy_out;

  modport slave (
    input  rx_data_in, rx_valid_in, tx_busy_in,
    output tx_data_out, tx_start_out, freq_word_out, phase_out, amp_out,
           wave_out, mode_out, cfg_update_out, ovf_out, busy_out
  );

  modport master (
    output rx_data_in, rx_valid_in, tx_busy_in,
    input  tx_data_out, tx_start_out, freq_word_out, phase_out, amp_out,
           wave_out, mode_out, cfg_update_out, ovf_out, busy_out
  );
endinterface

// File: rtl/dds_cmd_check.sv
// Combinational command validator.
//   cmd    : command byte (opcode [7:5], payload [4:0])
//   mode   : current operating mode (value before any write by this command)
//   accept : 1 when the command may be committed
module dds_cmd_check
  import dds_cmd_pkg::*;
(
  input  logic [7:0] cmd,
  input  logic [3:0] mode,
  output logic       accept
);

  logic [4:0] p;
  assign p = cmd[4:0];

  always_comb begin
    accept = 1'b0;
    case (opcode_e'(cmd[7:5]))
      OP_FREQ0, OP_FREQ1, OP_FREQ2, OP_FREQ3: accept = (cmd != 8'h00);
      OP_PHASE: accept = 1'b1;
      OP_AMP: begin
        if (mode == MODE_A)      accept = (p >= 5'd1) && (p <= 5'd5);
        else if (mode == MODE_B) accept = (p >= 5'd1) && (p <= 5'd8);
        else                     accept = 1'b0;
      end
      OP_WAVE: accept = is_onehot4(p[3:0]);
      OP_MODE: accept = ((mode == MODE_A) || (mode == MODE_B)) && is_onehot4(p[3:0]);
      default: accept = 1'b0;
    endcase
  end

endmodule

// File: rtl/dds_cmd_ctrl.sv
// DDS command sequencer: takes one UART byte at a time, validates it against
// the current mode, commits the payload to the matching DDS configuration
// register and returns a one-byte acknowledge over the UART TX handshake.
//   clk_in : system clock
//   rst_in : asynchronous active-high reset
//   bus    : RX byte/strobe, TX busy/data/start, DDS config outputs, status
module dds_cmd_ctrl
  import dds_cmd_pkg::*;
(
  input  logic           clk_in,
  input  logic           rst_in,
  dds_cmd_ctrl_if.slave  bus
);

  state_e      state, next_state;
  logic [7:0]  cmd_q;
  logic        accept, accept_q;
  logic [7:0]  tx_data_q;
  logic [19:0] freq_q;
  logic [4:0]  phase_q;
  logic [3:0]  amp_q;
  logic [3:0]  wave_q;
  logic [3:0]  mode_q;
  logic        cfg_update_q;
  logic        ovf_q;
  logic        seen_busy_q;
  logic        tx_start;

  dds_cmd_check u_check (
    .cmd    (cmd_q),
    .mode   (mode_q),
    .accept (accept)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  // tx_start is decoded from the state register so it drops immediately
  // when reset forces the FSM back to IDLE.
  always_comb begin
    next_state = state;
    tx_start   = 1'b0;
    case (state)
      IDLE:    if (bus.rx_valid_in) next_state = CHECK;
      CHECK:   next_state = APPLY;
      APPLY:   next_state = SEND;
      SEND: begin
        if (!bus.tx_busy_in) begin
          tx_start   = 1'b1;
          next_state = WAIT_TX;
        end
      end
      WAIT_TX: if (!bus.tx_busy_in && seen_busy_q) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cmd_q        <= '0;
      accept_q     <= 1'b0;
      tx_data_q    <= '0;
      freq_q       <= '0;
      phase_q      <= '0;
      amp_q        <= 4'd1;
      wave_q       <= 4'b0001;
      mode_q       <= RESET_MODE;
      cfg_update_q <= 1'b0;
      ovf_q        <= 1'b0;
      seen_busy_q  <= 1'b0;
    end else begin
      cfg_update_q <= 1'b0;

      if (bus.rx_valid_in) begin
        if (state == IDLE) cmd_q <= bus.rx_data_in;
        else               ovf_q <= 1'b1;
      end

      if (state == CHECK) begin
        accept_q  <= accept;
        tx_data_q <= accept ? ACK_OK : ACK_ERR;
      end

      if (state == APPLY && accept_q) begin
        cfg_update_q <= 1'b1;
        case (opcode_e'(cmd_q[7:5]))
          OP_FREQ0: freq_q[4:0]   <= cmd_q[4:0];
          OP_FREQ1: freq_q[9:5]   <= cmd_q[4:0];
          OP_FREQ2: freq_q[14:10] <= cmd_q[4:0];
          OP_FREQ3: freq_q[19:15] <= cmd_q[4:0];
          OP_PHASE: phase_q       <= cmd_q[4:0];
          OP_AMP:   amp_q         <= cmd_q[3:0];
          OP_WAVE:  wave_q        <= cmd_q[3:0];
          OP_MODE:  mode_q        <= cmd_q[3:0];
          default:  ;
        endcase
      end

      // Busy only counts once the TX has been started for this command.
      if (state == SEND)                          seen_busy_q <= 1'b0;
      else if (state == WAIT_TX && bus.tx_busy_in) seen_busy_q <= 1'b1;
    end
  end

  assign bus.tx_data_out    = tx_data_q;
  assign bus.tx_start_out   = tx_start;
  assign bus.freq_word_out  = freq_q;
  assign bus.phase_out      = phase_q;
  assign bus.amp_out        = amp_q;
  assign bus.wave_out       = wave_q;
  assign bus.mode_out       = mode_q;
  assign bus.cfg_update_out = cfg_update_q;
  assign bus.ovf_out        = ovf_q;
  assign bus.busy_out       = (state != IDLE);

endmodule

// File: tb/tb_dds_cmd_ctrl.sv
module tb_dds_cmd_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dds_cmd_ctrl_if bus();

  dds_cmd_ctrl dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  // Stand-alone validator instance
  logic [7:0] chk_cmd;
  logic [3:0] chk_mode;
  logic       chk_acc;
  dds_cmd_check u_chk (
    .cmd    (chk_cmd),
    .mode   (chk_mode),
    .accept (chk_acc)
  );

  // TX model: busy for busy_len cycles starting the cycle after tx_start
  int   busy_len = 10;
  int   tx_cnt;
  logic hold_busy = 1'b0;
  assign bus.tx_busy_in = hold_busy | (tx_cnt != 0);

  int         start_cnt;
  int         cfg_cnt;
  logic [7:0] last_ack;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt <= 0;
    end else if (bus.tx_start_out) begin
      tx_cnt <= busy_len;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
    end
  end

  initial begin
    start_cnt = 0;
    cfg_cnt   = 0;
    last_ack  = 8'h00;
  end

  always @(posedge clk) begin
    if (bus.tx_start_out) begin
      start_cnt <= start_cnt + 1;
      last_ack  <= bus.tx_data_out;
    end
    if (bus.cfg_update_out) cfg_cnt <= cfg_cnt + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data_in  = b;
    bus.rx_valid_in = 1'b1;
    step();
    bus.rx_valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy_out && n < 300) begin
      step();
      n++;
    end
    chk(tag, {31'd0, bus.busy_out}, 32'd0);
  endtask

  task automatic do_cmd(input string tag, input logic [7:0] b,
                        input logic [7:0] ack, input int cfg_delta);
    int s0, c0;
    s0 = start_cnt;
    c0 = cfg_cnt;
    send(b);
    wait_idle({tag, "_idle"});
    chk({tag, "_ack"}, {24'd0, last_ack}, {24'd0, ack});
    chk({tag, "_starts"}, start_cnt - s0, 32'd1);
    chk({tag, "_updates"}, cfg_cnt - c0, cfg_delta);
    step();
  endtask

  task automatic unit(input logic [7:0] c, input logic [3:0] m, input logic exp);
    chk_cmd  = c;
    chk_mode = m;
    #1;
    chk($sformatf("check_%02h_m%0h", c, m), {31'd0, chk_acc}, {31'd0, exp});
  endtask

  initial begin
    int s0;
    bus.rx_data_in  = 8'h00;
    bus.rx_valid_in = 1'b0;
    chk_cmd  = 8'h00;
    chk_mode = 4'b0001;

    // Validator table
    unit(8'h00, 4'b0001, 1'b0);
    unit(8'h20, 4'b0001, 1'b1);
    unit(8'h80, 4'b0100, 1'b1);
    unit(8'hA5, 4'b0001, 1'b1);
    unit(8'hA6, 4'b0001, 1'b0);
    unit(8'hA0, 4'b0010, 1'b0);
    unit(8'hA8, 4'b0010, 1'b1);
    unit(8'hA9, 4'b0010, 1'b0);
    unit(8'hA1, 4'b0100, 1'b0);
    unit(8'hD0, 4'b0001, 1'b0);
    unit(8'hD8, 4'b0100, 1'b1);
    unit(8'hE8, 4'b0010, 1'b1);
    unit(8'hE8, 4'b1000, 1'b0);
    unit(8'hE3, 4'b0001, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("rst_tx_data",  {24'd0, bus.tx_data_out}, 32'h00);
    chk("rst_tx_start", {31'd0, bus.tx_start_out}, 32'd0);
    chk("rst_freq",     {12'd0, bus.freq_word_out}, 32'd0);
    chk("rst_phase",    {27'd0, bus.phase_out}, 32'd0);
    chk("rst_amp",      {28'd0, bus.amp_out}, 32'd1);
    chk("rst_wave",     {28'd0, bus.wave_out}, 32'b0001);
    chk("rst_mode",     {28'd0, bus.mode_out}, 32'b0001);
    chk("rst_cfg",      {31'd0, bus.cfg_update_out}, 32'd0);
    chk("rst_ovf",      {31'd0, bus.ovf_out}, 32'd0);
    chk("rst_busy",     {31'd0, bus.busy_out}, 32'd0);

    // 8'h3A with cycle-by-cycle timing (now at N+1 after send)
    s0 = start_cnt;
    send(8'h3A);
    chk("t3a_busy_n1", {31'd0, bus.busy_out}, 32'd1);
    chk("t3a_cfg_n1",  {31'd0, bus.cfg_update_out}, 32'd0);
    step();
    chk("t3a_txdata_n2", {24'd0, bus.tx_data_out}, 32'h01);
    chk("t3a_cfg_n2",    {31'd0, bus.cfg_update_out}, 32'd0);
    step();
    chk("t3a_cfg_n3",   {31'd0, bus.cfg_update_out}, 32'd1);
    chk("t3a_freq_n3",  {12'd0, bus.freq_word_out}, 32'h340);
    chk("t3a_start_n3", {31'd0, bus.tx_start_out}, 32'd1);
    step();
    chk("t3a_cfg_n4",   {31'd0, bus.cfg_update_out}, 32'd0);
    chk("t3a_start_n4", {31'd0, bus.tx_start_out}, 32'd0);
    chk("t3a_txbusy_n4", {31'd0, bus.tx_busy_in}, 32'd1);
    wait_idle("t3a_idle");
    chk("t3a_starts", start_cnt - s0, 32'd1);
    chk("t3a_ack",    {24'd0, last_ack}, 32'h01);
    chk("t3a_ovf",    {31'd0, bus.ovf_out}, 32'd0);
    step();

    // Amplitude limits depend on mode
    do_cmd("amp8_modeA", 8'hA8, 8'hFF, 0);
    chk("amp8_modeA_amp", {28'd0, bus.amp_out}, 32'd1);
    do_cmd("mode_B", 8'hE2, 8'h01, 1);
    chk("mode_B_mode", {28'd0, bus.mode_out}, 32'b0010);
    do_cmd("amp8_modeB", 8'hA8, 8'h01, 1);
    chk("amp8_modeB_amp", {28'd0, bus.amp_out}, 32'd8);

    // Rejections
    do_cmd("mode_bad", 8'hE3, 8'hFF, 0);
    chk("mode_bad_mode", {28'd0, bus.mode_out}, 32'b0010);
    do_cmd("zero_byte", 8'h00, 8'hFF, 0);
    chk("zero_byte_freq", {12'd0, bus.freq_word_out}, 32'h340);

    // TX busy held before SEND; overrun during WAIT_TX
    s0 = start_cnt;
    hold_busy = 1'b1;
    send(8'h85);
    repeat (20) step();
    chk("hold_no_start", start_cnt - s0, 32'd0);
    chk("hold_busy_out", {31'd0, bus.busy_out}, 32'd1);
    chk("hold_phase",    {27'd0, bus.phase_out}, 32'd5);
    hold_busy = 1'b0;
    #1;
    chk("hold_start_now", {31'd0, bus.tx_start_out}, 32'd1);
    step();
    chk("ovf_before", {31'd0, bus.ovf_out}, 32'd0);
    send(8'h9F);
    chk("ovf_set", {31'd0, bus.ovf_out}, 32'd1);
    wait_idle("ovf_idle");
    chk("ovf_phase",  {27'd0, bus.phase_out}, 32'd5);
    chk("ovf_starts", start_cnt - s0, 32'd1);
    chk("ovf_ack",    {24'd0, last_ack}, 32'h01);
    chk("ovf_sticky", {31'd0, bus.ovf_out}, 32'd1);
    step();

    // Reset during WAIT_TX
    send(8'h1F);
    step();
    step();
    step();
    chk("rst_mid_busy_pre", {31'd0, bus.busy_out}, 32'd1);
    s0 = start_cnt;
    #3;
    rst = 1'b1;
    #1;
    chk("rstmid_freq",    {12'd0, bus.freq_word_out}, 32'd0);
    chk("rstmid_txdata",  {24'd0, bus.tx_data_out}, 32'h00);
    chk("rstmid_mode",    {28'd0, bus.mode_out}, 32'b0001);
    chk("rstmid_amp",     {28'd0, bus.amp_out}, 32'd1);
    chk("rstmid_phase",   {27'd0, bus.phase_out}, 32'd0);
    chk("rstmid_ovf",     {31'd0, bus.ovf_out}, 32'd0);
    chk("rstmid_busy",    {31'd0, bus.busy_out}, 32'd0);
    chk("rstmid_start",   {31'd0, bus.tx_start_out}, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    step();
    step();
    chk("rstmid_no_start", start_cnt - s0, 32'd0);
    do_cmd("wave4", 8'hC4, 8'h01, 1);
    chk("wave4_wave", {28'd0, bus.wave_out}, 32'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
